// File: rtl/bp_me_pkg.sv
// Shared types for the BedRock register master: message enums, the
// mem header layout, FSM states and the critical-dword replication helper.
package bp_me_pkg;

    localparam int dword_width_gp   = 64;
    localparam int paddr_width_gp   = 40;
    localparam int payload_width_gp = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_gp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_send  = 2'd1,
        e_wait  = 2'd2,
        e_done  = 2'd3
    } bp_me_reg_master_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Timeout counter must be able to hold timeout_p itself.
    function automatic int timeout_cnt_width(input int timeout);
        return safe_clog2(timeout + 1);
    endfunction

    // Spread a right-justified value across the whole dword by size.
    function automatic logic [63:0] replicate_by_size(
        input logic [63:0] d,
        input logic [1:0]  sz
    );
        logic [63:0] r;
        r = d;
        case (sz)
            2'd0:    r = {8{d[7:0]}};
            2'd1:    r = {4{d[15:0]}};
            2'd2:    r = {2{d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bsg_dff_en.sv
// Plain enable flop, no reset; holds its value while en_i is low.
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Load on enable, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (en_i) data_o <= data_i;
    end

endmodule

// File: rtl/bp_me_bedrock_register_master.sv
// Single-outstanding register request to BedRock mem command bridge,
// with a response watchdog and drain of late (stale) responses.
module bp_me_bedrock_register_master
    import bp_me_pkg::*;
#(
    parameter int reg_width_p      = dword_width_gp,
    parameter int reg_addr_width_p = paddr_width_gp,
    parameter int timeout_p        = 1024,
    localparam int size_width_lp   = safe_clog2($clog2(reg_width_p/8)),
    localparam int mem_header_width_lp = mem_header_width_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           r_v_i,
    input  logic                           w_v_i,
    input  logic [reg_addr_width_p-1:0]    addr_i,
    input  logic [size_width_lp-1:0]       size_i,
    input  logic [reg_width_p-1:0]         data_i,
    output logic                           ready_and_o,

    output logic                           v_o,
    output logic [reg_width_p-1:0]         data_o,
    output logic                           err_o,
    input  logic                           yumi_i,

    output logic [mem_header_width_lp-1:0] mem_cmd_header_o,
    output logic [63:0]                    mem_cmd_critical_o,
    output logic                           mem_cmd_header_v_o,
    input  logic                           mem_cmd_header_ready_and_i,

    input  logic [mem_header_width_lp-1:0] mem_resp_header_i,
    input  logic [63:0]                    mem_resp_critical_i,
    input  logic                           mem_resp_header_v_i,
    output logic                           mem_resp_header_ready_and_o
);

    if (reg_width_p != dword_width_gp) begin : g_bad_width
        $error("reg_width_p must be 64");
    end

    localparam int cnt_width_lp = timeout_cnt_width(timeout_p);
    localparam bit timeout_en_lp = (timeout_p != 0);

    bp_me_reg_master_state_e state_r;
    logic                    stale_r;
    logic [cnt_width_lp-1:0] cnt_r;

    bp_bedrock_mem_header_s         hdr_n, hdr_r, resp_hdr;
    logic [mem_header_width_lp-1:0] hdr_q;
    logic [63:0]                    crit_n, crit_q;

    logic accept, cmd_hs, resp_hs;
    logic in_wait, stale_drop, timeout_hit;
    logic unused_resp_bits;

    assign in_wait = (state_r == e_wait);

    assign ready_and_o = (state_r == e_ready) & ~stale_r;
    assign mem_resp_header_ready_and_o = in_wait | stale_r;

    assign accept  = ready_and_o & (r_v_i | w_v_i);
    assign cmd_hs  = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
    assign resp_hs = mem_resp_header_v_i & mem_resp_header_ready_and_o;

    assign stale_drop  = resp_hs & ~in_wait;
    assign timeout_hit = timeout_en_lp
                       & (cnt_r == cnt_width_lp'(timeout_p - 1));

    assign resp_hdr = mem_resp_header_i;
    assign unused_resp_bits = ^mem_resp_header_i;

    // Build the outgoing header and critical dword from the request.
    always_comb begin
        hdr_n          = '0;
        hdr_n.msg_type = w_v_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        hdr_n.addr     = paddr_width_gp'(addr_i);
        hdr_n.size     = bp_bedrock_msg_size_e'(3'(size_i));
        hdr_n.payload  = '0;
        crit_n = replicate_by_size(64'(data_i), 2'(size_i));
    end

    bsg_dff_en #(.width_p(mem_header_width_lp)) hdr_reg (
        .clk_i  (clk_i),
        .en_i   (accept),
        .data_i (hdr_n),
        .data_o (hdr_q)
    );

    bsg_dff_en #(.width_p(64)) crit_reg (
        .clk_i  (clk_i),
        .en_i   (accept),
        .data_i (crit_n),
        .data_o (crit_q)
    );

    assign hdr_r              = hdr_q;
    assign mem_cmd_header_o   = hdr_q;
    assign mem_cmd_critical_o = crit_q;

    // Request FSM, watchdog counter, stale tracking and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r            <= e_ready;
            stale_r            <= 1'b0;
            cnt_r              <= '0;
            v_o                <= 1'b0;
            err_o              <= 1'b0;
            data_o             <= '0;
            mem_cmd_header_v_o <= 1'b0;
        end else begin
            if (stale_drop) stale_r <= 1'b0;
            unique case (state_r)
                e_ready: begin
                    if (accept) begin
                        mem_cmd_header_v_o <= 1'b1;
                        state_r            <= e_send;
                    end
                end
                e_send: begin
                    if (cmd_hs) begin
                        mem_cmd_header_v_o <= 1'b0;
                        cnt_r              <= '0;
                        state_r            <= e_wait;
                    end
                end
                e_wait: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (resp_hs) begin
                        data_o  <= (hdr_r.msg_type == e_bedrock_mem_uc_wr)
                                 ? '0
                                 : reg_width_p'(mem_resp_critical_i);
                        err_o   <= 1'b0;
                        v_o     <= 1'b1;
                        state_r <= e_done;
                    end else if (timeout_hit) begin
                        data_o  <= '0;
                        err_o   <= 1'b1;
                        stale_r <= 1'b1;
                        v_o     <= 1'b1;
                        state_r <= e_done;
                    end
                end
                e_done: begin
                    if (yumi_i) begin
                        v_o     <= 1'b0;
                        err_o   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= e_ready;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    // Protocol checks on the request and response sides.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(state_r == e_ready && r_v_i && w_v_i))
                else $error("read and write requested together");
            assert (!(yumi_i && !v_o))
                else $error("yumi without a valid completion");
            if (in_wait && resp_hs) begin
                assert (resp_hdr.msg_type == hdr_r.msg_type)
                    else $error("response msg_type differs from command");
                assert (resp_hdr.addr == hdr_r.addr)
                    else $error("response addr differs from command");
            end
        end
    end

endmodule
